vga_timing_generator: RTL and testbench
=======================================

// Module: vga_timing_generator
// PURPOSE
//   Generates the VGA raster: active-low hsync/vsync, pixel coordinates, blanking and
//   line-fetch strobes for the video peripheral's pixel pipeline. It drives the sync
//   pins (mprj_io[37:36]) checked by the video testbench. Default timing is 800x600@60
//   with horizontal counts divided by 8, at the 40 MHz user clock:
//   hsync 0.4 us, line 3.3 us, vsync 13.2 us, frame 2072.4 us.
// PARAMETERS
//   H_VISIBLE   100  visible clocks per line
//   H_FRONT       5  horizontal front porch, clocks
//   H_SYNC       16  hsync pulse width, clocks
//   H_BACK       11  horizontal back porch, clocks (H_TOTAL = 132)
//   V_VISIBLE   600  visible lines per frame
//   V_FRONT       1  vertical front porch, lines
//   V_SYNC        4  vsync pulse width, lines
//   V_BACK       23  vertical back porch, lines (V_TOTAL = 628)
// PORTS
//   clk          in   1   user clock, 40 MHz
//   rst_n        in   1   asynchronous active-low reset
//   enable       in   1   run request from the video control register
//   running      out  1   generator is producing frames
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   visible      out  1   current clock lies in the visible area
//   pixel_x      out  HW  horizontal count, 0..H_TOTAL-1 (HW = clog2(H_TOTAL))
//   pixel_y      out  VW  vertical count, 0..V_TOTAL-1 (VW = clog2(V_TOTAL))
//   line_start   out  1   1-clock pulse at h==0 of a visible line
//   frame_start  out  1   1-clock pulse at h==0, v==0
//   fetch_line   out  1   1-clock pulse requesting the line buffer to load fetch_row
//   fetch_row    out  VW  row to fetch, valid while fetch_line is high
// BEHAVIOUR
//   - Reset values: running=0, hsync=1, vsync=1, visible=0, pixel_x=0, pixel_y=0.
//     All pulse outputs are 0 and fetch_row is 0.
//   - FSM states:
//     IDLE: counters held at 0, syncs inactive. Goes to RUN on the first clock with
//       enable=1. The first active edge gives h=0, v=0, frame_start=1.
//     RUN: h increments every clock. When h wraps H_TOTAL-1 -> 0, v increments.
//       v wraps V_TOTAL-1 -> 0.
//     RUN with enable=0: goes to STOP_PENDING. The frame is never truncated.
//     STOP_PENDING: keeps counting. Returns to RUN if enable=1 again before the frame
//       ends. Goes to IDLE on the edge where h=H_TOTAL-1 and v=V_TOTAL-1; that edge
//       loads zeros and inactive syncs.
//   - All outputs are registered and decoded from next-state counters, so they align
//     with pixel_x/pixel_y on the same cycle. Latency from an enable change is 1 clock.
//   - hsync=0 when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
//   - vsync=0 for whole lines with V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
//     It changes only when h=0.
//   - visible = (h < H_VISIBLE) && (v < V_VISIBLE).
//   - fetch_line pulses at h==H_VISIBLE when row (v+1) mod V_TOTAL < V_VISIBLE.
//     fetch_row = (v+1) mod V_TOTAL. The last line of the frame therefore requests
//     row 0, and no fetch occurs at v = V_VISIBLE-1.
//   - Counter widths are derived with $clog2. Wrap compares use == TOTAL-1, never
//     overflow. running=1 in RUN and STOP_PENDING.
//   - Async reset mid-frame forces the reset values immediately. After release the
//     FSM restarts from IDLE.
// STRUCTURE
//   - Shared package video_pkg: FSM state typedef (IDLE, RUN, STOP_PENDING), default
//     timing localparams, and H_TOTAL/V_TOTAL width helper functions.
//   - One sub-module, video_axis_counter (count, wrap strobe, region decode), is
//     instantiated twice: horizontal, and vertical enabled by the horizontal wrap.
// TESTING
//   - Reset, then enable=1 -> frame_start 1 clock later. hsync low for exactly 16 clocks,
//     period 132 clocks (0.4 us / 3.3 us).
//   - Run a full frame -> vsync low 528 clocks, period 82896 clocks (13.2 us / 2072.4 us).
//     Exactly 600 line_start pulses per frame.
//   - Check visible per line -> high for 100 clocks on lines 0..599, never high on
//     lines 600..627.
//   - Check fetch strobes -> fetch_line at h=100 with fetch_row=v+1 for v=0..598, and
//     fetch_row=0 at v=627. No pulse at v=599..626.
//   - Drop enable at v=300 -> running stays 1 until frame end, then syncs go high and
//     counters 0. Re-assert enable at v=400 -> no stop occurs.
//   - Assert rst_n=0 mid-hsync -> hsync=1, pixel_x=0 immediately. Re-enable and check
//     the first full frame has nominal timing.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: generator FSM states, default raster timing and width helpers.
package video_pkg;

  // Default 800x600@60 timing, horizontal counts divided by 8 (40 MHz pixel clock).
  localparam int unsigned DefHVisible = 100;
  localparam int unsigned DefHFront   = 5;
  localparam int unsigned DefHSync    = 16;
  localparam int unsigned DefHBack    = 11;
  localparam int unsigned DefVVisible = 600;
  localparam int unsigned DefVFront   = 1;
  localparam int unsigned DefVSync    = 4;
  localparam int unsigned DefVBack    = 23;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StRun         = 2'd1,
    StStopPending = 2'd2
  } vga_state_e;

  // Total count of one axis (line length in clocks or frame height in lines).
  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

  // Counter width able to hold 0..total-1, never narrower than one bit.
  function automatic int unsigned axis_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping counter plus visible/sync decode of its next value.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int unsigned TOTAL      = 132,
  parameter int unsigned VISIBLE    = 100,
  parameter int unsigned SYNC_START = 105,
  parameter int unsigned SYNC_END   = 121,
  localparam int unsigned W         = axis_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic [W-1:0] next_count,
  output logic         wrap,
  output logic         next_visible,
  output logic         next_sync
);

  localparam logic [W-1:0] LastCount = W'(TOTAL - 1);

  assign wrap = advance && (count == LastCount);

  // Next count: clear wins, otherwise step and wrap at TOTAL-1 without relying on overflow.
  always_comb begin
    next_count = count;
    if (clear) begin
      next_count = '0;
    end else if (advance) begin
      next_count = wrap ? '0 : count + 1'b1;
    end
  end

  // Region decode on the next value so registered outputs line up with the count.
  always_comb begin
    next_visible = (32'(next_count) < VISIBLE);
    next_sync    = (32'(next_count) >= SYNC_START) && (32'(next_count) < SYNC_END);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster generator: run/stop FSM, two axis counters and registered sync/strobe outputs.
module vga_timing_generator
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DefHVisible,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_VISIBLE = DefVVisible,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack,
  localparam int unsigned H_TOTAL  = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int unsigned V_TOTAL  = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int unsigned HW       = axis_width(H_TOTAL),
  localparam int unsigned VW       = axis_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          running,
  output logic          hsync,
  output logic          vsync,
  output logic          visible,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_line,
  output logic [VW-1:0] fetch_row
);

  localparam logic [HW-1:0] HVisibleC = HW'(H_VISIBLE);
  localparam logic [VW-1:0] VLastC    = VW'(V_TOTAL - 1);

  vga_state_e    state_q, state_d;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic [VW-1:0] row_next;
  logic          h_wrap, v_wrap;
  logic          h_next_vis, h_next_sync;
  logic          v_next_vis, v_next_sync;
  logic          counting, clear, run_d, fetch_d;

  // Counters advance only once running; entering or staying in idle forces them to zero.
  assign counting = (state_q != StIdle);
  assign clear    = (state_d == StIdle);
  assign run_d    = ~clear;

  video_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .advance      (counting),
    .count        (pixel_x),
    .next_count   (h_next),
    .wrap         (h_wrap),
    .next_visible (h_next_vis),
    .next_sync    (h_next_sync)
  );

  video_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .advance      (h_wrap),
    .count        (pixel_y),
    .next_count   (v_next),
    .wrap         (v_wrap),
    .next_visible (v_next_vis),
    .next_sync    (v_next_sync)
  );

  // Run/stop control: a stop request only takes effect on the last clock of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) state_d = StStopPending;
      end
      StStopPending: begin
        if (enable) begin
          state_d = StRun;
        end else if (v_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line-buffer prefetch targets the next row; the last frame line requests row 0.
  always_comb begin
    row_next = (v_next == VLastC) ? '0 : v_next + 1'b1;
    fetch_d  = run_d && (h_next == HVisibleC) && (32'(row_next) < V_VISIBLE);
  end

  // State and output registers, all decoded from next-state counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      running     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_line  <= 1'b0;
      fetch_row   <= '0;
    end else begin
      state_q     <= state_d;
      running     <= run_d;
      hsync       <= ~(run_d & h_next_sync);
      vsync       <= ~(run_d & v_next_sync);
      visible     <= run_d & h_next_vis & v_next_vis;
      line_start  <= run_d & (h_next == '0) & v_next_vis;
      frame_start <= run_d & (h_next == '0) & (v_next == '0);
      fetch_line  <= fetch_d;
      fetch_row   <= fetch_d ? row_next : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: frame-position reference model plus scenario tasks.
// Horizontal timing is the default; vertical timing is shrunk so whole frames stay short.
module tb_vga_timing_generator;

  localparam int HV = 100, HF = 5, HS = 16, HB = 11;
  localparam int VV = 20, VF = 1, VS = 4, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic          clk, rst_n, enable;
  logic          running, hsync, vsync, visible, line_start, frame_start, fetch_line;
  logic [HW-1:0] pixel_x;
  logic [VW-1:0] pixel_y, fetch_row;

  int checks = 0;
  int errors = 0;

  // Reference: running flag, pending-stop flag and linear position within the frame.
  bit m_run, m_pending;
  int m_pos;

  vga_timing_generator #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .running     (running),
    .hsync       (hsync),
    .vsync       (vsync),
    .visible     (visible),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .fetch_line  (fetch_line),
    .fetch_row   (fetch_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model step: a stop takes effect only at frame end if enable was already low a clock earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pos <= 0; m_pending <= 1'b0;
    end else if (!m_run) begin
      if (enable) begin
        m_run <= 1'b1; m_pos <= 0; m_pending <= 1'b0;
      end
    end else begin
      if (m_pending && !enable && m_pos == FRAME - 1) begin
        m_run <= 1'b0; m_pos <= 0;
      end else begin
        m_pos <= (m_pos + 1) % FRAME;
      end
      m_pending <= !enable;
    end
  end

  function automatic logic [63:0] exp_vec(input bit run, input int pos);
    int h, v, nrow;
    logic hs_e, vs_e, vis_e, ls_e, fs_e, fl_e;
    logic [VW-1:0] fr_e;
    h = pos % HT;
    v = pos / HT;
    nrow = (v + 1) % VT;
    hs_e = !(run && h >= HV + HF && h < HV + HF + HS);
    vs_e = !(run && v >= VV + VF && v < VV + VF + VS);
    vis_e = run && h < HV && v < VV;
    ls_e = run && h == 0 && v < VV;
    fs_e = run && pos == 0;
    fl_e = run && h == HV && nrow < VV;
    fr_e = fl_e ? VW'(nrow) : {VW{1'b0}};
    return 64'({run, hs_e, vs_e, vis_e, HW'(h), VW'(v), ls_e, fs_e, fl_e, fr_e});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({running, hsync, vsync, visible, pixel_x, pixel_y, line_start, frame_start,
                fetch_line, (fetch_line ? fetch_row : {VW{1'b0}})});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
    checks++; if (visible !== 1'b0) begin errors++; $display("FAIL reset_visible got %b want 0", visible); end
    checks++; if (pixel_x !== '0 || pixel_y !== '0) begin
      errors++; $display("FAIL reset_pixel got x=%0d y=%0d want 0 0", pixel_x, pixel_y);
    end
    checks++; if ({line_start, frame_start, fetch_line} !== 3'b000 || fetch_row !== '0) begin
      errors++; $display("FAIL reset_pulses got %b row=%0d want 000 row=0",
                         {line_start, frame_start, fetch_line}, fetch_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL idle_hold got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
    end
  endtask

  task automatic test_start_hsync();
    int falls[$];
    int widths[$];
    int low;
    logic prev;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || running !== 1'b1 || pixel_x !== '0 || pixel_y !== '0) begin
      errors++; $display("FAIL start_latency got fs=%b run=%b x=%0d y=%0d want 1 1 0 0",
                         frame_start, running, pixel_x, pixel_y);
    end
    prev = hsync;
    low = 0;
    for (int c = 1; c < 4 * HT; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL line_model c=%0d got %h want %h", c, dut_vec(), exp_vec(m_run, m_pos));
      end
      if (!hsync) low++;
      if (prev && !hsync) falls.push_back(c);
      if (!prev && hsync) begin widths.push_back(low); low = 0; end
      prev = hsync;
    end
    checks++;
    if (falls.size() != 4 || widths.size() != 4) begin
      errors++; $display("FAIL hsync_pulses got %0d/%0d want 4/4", falls.size(), widths.size());
    end else begin
      checks++;
      if (falls[0] != HV + HF) begin
        errors++; $display("FAIL hsync_first got %0d want %0d", falls[0], HV + HF);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (widths[i] != HS) begin errors++; $display("FAIL hsync_width got %0d want %0d", widths[i], HS); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (falls[i] - falls[i-1] != HT) begin
          errors++; $display("FAIL hsync_period got %0d want %0d", falls[i] - falls[i-1], HT);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int vis_cnt[VT];
    int vfalls[$];
    int vlow, ls_cnt, fl_cnt, fs_cnt, waited;
    logic prev;
    waited = 0;
    while (frame_start !== 1'b1 && waited < 2 * FRAME) begin
      @(negedge clk); waited++;
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL frame_wait got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_timeout got 0 want 1"); end
    foreach (vis_cnt[i]) vis_cnt[i] = 0;
    vlow = 0; ls_cnt = 0; fl_cnt = 0; fs_cnt = 0;
    prev = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++;
        if (dut_vec() !== exp_vec(m_run, m_pos)) begin
          errors++; $display("FAIL frame_model c=%0d got %h want %h", c, dut_vec(), exp_vec(m_run, m_pos));
        end
        if (frame_start) fs_cnt++;
      end
      if (c < FRAME) begin
        if (visible) vis_cnt[c / HT]++;
        if (!vsync) vlow++;
        if (line_start) ls_cnt++;
        if (fetch_line) fl_cnt++;
      end
      if (prev && !vsync) vfalls.push_back(c);
      prev = vsync;
    end
    checks++; if (vlow != VS * HT) begin errors++; $display("FAIL vsync_width got %0d want %0d", vlow, VS * HT); end
    checks++; if (ls_cnt != VV) begin errors++; $display("FAIL line_starts got %0d want %0d", ls_cnt, VV); end
    checks++; if (fl_cnt != VV) begin errors++; $display("FAIL fetch_count got %0d want %0d", fl_cnt, VV); end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_starts got %0d want 1", fs_cnt); end
    checks++;
    if (vfalls.size() != 2) begin
      errors++; $display("FAIL vsync_falls got %0d want 2", vfalls.size());
    end else begin
      checks++;
      if (vfalls[0] != (VV + VF) * HT) begin
        errors++; $display("FAIL vsync_first got %0d want %0d", vfalls[0], (VV + VF) * HT);
      end
      checks++;
      if (vfalls[1] - vfalls[0] != FRAME) begin
        errors++; $display("FAIL vsync_period got %0d want %0d", vfalls[1] - vfalls[0], FRAME);
      end
    end
    for (int l = 0; l < VT; l++) begin
      checks++;
      if (vis_cnt[l] != ((l < VV) ? HV : 0)) begin
        errors++; $display("FAIL visible_line%0d got %0d want %0d", l, vis_cnt[l], (l < VV) ? HV : 0);
      end
    end
  endtask

  task automatic test_stop();
    int waited, run_cycles;
    waited = 0;
    while (!(pixel_y === VW'(10) && pixel_x === '0) && waited < 2 * FRAME) begin
      @(negedge clk); waited++;
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL stop_wait got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
    end
    enable = 1'b0;
    run_cycles = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL stop_model got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
      if (!running) break;
      run_cycles++;
    end
    checks++;
    if (run_cycles != FRAME - 1 - 10 * HT) begin
      errors++; $display("FAIL stop_drain got %0d want %0d", run_cycles, FRAME - 1 - 10 * HT);
    end
    checks++;
    if ({running, hsync, vsync} !== 3'b011 || pixel_x !== '0 || pixel_y !== '0) begin
      errors++; $display("FAIL stop_idle got run/hs/vs=%b x=%0d y=%0d want 011 0 0",
                         {running, hsync, vsync}, pixel_x, pixel_y);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (running !== 1'b0 || pixel_x !== '0) begin
        errors++; $display("FAIL stop_stays got run=%b x=%0d want 0 0", running, pixel_x);
      end
    end
  endtask

  task automatic test_stop_cancel();
    int waited, idle_cycles;
    enable = 1'b1;
    waited = 0;
    while (!(pixel_y === VW'(10) && pixel_x === '0) && waited < 2 * FRAME) begin
      @(negedge clk); waited++;
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL cancel_wait got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
    end
    enable = 1'b0;
    idle_cycles = 0;
    waited = 0;
    while (!(pixel_y === VW'(14) && pixel_x === '0) && waited < 2 * FRAME) begin
      @(negedge clk); waited++;
      if (!running) idle_cycles++;
    end
    enable = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (!running) idle_cycles++;
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL cancel_model got %h want %h", dut_vec(), exp_vec(m_run, m_pos));
      end
    end
    checks++;
    if (idle_cycles != 0) begin errors++; $display("FAIL cancel_no_stop got %0d idle want 0", idle_cycles); end
  endtask

  task automatic test_async_reset();
    int waited, hlow, vlow;
    waited = 0;
    while (!(pixel_x === HW'(HV + HF + 8)) && waited < 2 * HT) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL areset_setup got hsync=%b want 0", hsync); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hsync !== 1'b1 || pixel_x !== '0 || running !== 1'b0) begin
      errors++; $display("FAIL areset_immediate got hs=%b x=%0d run=%b want 1 0 0", hsync, pixel_x, running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || pixel_x !== '0 || pixel_y !== '0) begin
      errors++; $display("FAIL areset_restart got fs=%b x=%0d y=%0d want 1 0 0", frame_start, pixel_x, pixel_y);
    end
    hlow = (hsync === 1'b0) ? 1 : 0;
    vlow = (vsync === 1'b0) ? 1 : 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL areset_model c=%0d got %h want %h", c, dut_vec(), exp_vec(m_run, m_pos));
      end
      if (c < FRAME) begin
        if (!hsync) hlow++;
        if (!vsync) vlow++;
      end
    end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL areset_frame_len got fs=0 want 1"); end
    checks++; if (hlow != HS * VT) begin errors++; $display("FAIL areset_hsync got %0d want %0d", hlow, HS * VT); end
    checks++; if (vlow != VS * HT) begin errors++; $display("FAIL areset_vsync got %0d want %0d", vlow, VS * HT); end
  endtask

  task automatic test_random_enable();
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec(m_run, m_pos)) begin
        errors++; $display("FAIL random_model c=%0d got %h want %h", c, dut_vec(), exp_vec(m_run, m_pos));
      end
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    test_reset();
    test_start_hsync();
    test_full_frame();
    test_stop();
    test_stop_cancel();
    test_async_reset();
    test_random_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
